// File: rtl/telem_pkg.sv
// telem_pkg
//   Shared definitions for the telemetry target table:
//   - coordinate index constants for the packed record layout
//     (coordinate k lives at bits [k*COORD_W +: COORD_W])
//   - scan engine state encoding
//   - address-width helper used to size slot indices
package telem_pkg;

  localparam int COORD_X = 0;
  localparam int COORD_Y = 1;
  localparam int COORD_Z = 2;
  localparam int COORD_T = 3;

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_SEEK,
    SCAN_PRESENT,
    SCAN_DONE
  } scan_state_t;

  // Width of a slot index; never narrower than one bit so a single-slot
  // table still has a legal address port.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/telem_slot.sv
// telem_slot
//   One target record: data register, valid bit and, when TELEM_AGE_EN is
//   defined, a saturating age counter that expires the entry.
//
// Configuration macro: TELEM_AGE_EN (adds age_tick port and age counter)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   age_tick   in   age advance strobe (TELEM_AGE_EN only)
//   load       in   load wr_data and mark valid
//   clear      in   zero the record and mark invalid (beats load)
//   wr_data    in   record to load
//   data       out  stored record
//   valid      out  registered valid bit
//   valid_nxt  out  value valid takes on the next edge (feeds the count)
module telem_slot #(
  parameter int DATA_W = 32
`ifdef TELEM_AGE_EN
  , parameter int AGE_LIMIT = 200
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef TELEM_AGE_EN
  input  logic              age_tick,
`endif
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              valid_nxt
);

`ifdef TELEM_AGE_EN
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  logic [AGE_W-1:0] age;
  logic             expire;

  // The entry expires on the tick that would carry its age up to the limit.
  assign expire = age_tick && valid && (age == AGE_W'(AGE_LIMIT - 1));

  // Age restarts on every load or clear and saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age <= '0;
    end else if (clear || load) begin
      age <= '0;
    end else if (age_tick && valid && (age != AGE_W'(AGE_LIMIT))) begin
      age <= age + 1'b1;
    end
  end
`endif

  // Next valid state: clear beats load, and a load beats expiry.
  always_comb begin
    valid_nxt = valid;
    if (clear) begin
      valid_nxt = 1'b0;
    end else if (load) begin
      valid_nxt = 1'b1;
    end
`ifdef TELEM_AGE_EN
    else if (expire) begin
      valid_nxt = 1'b0;
    end
`endif
  end

  // Expiry only drops the valid bit; the record contents are retained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= valid_nxt;
      if (clear) begin
        data <= '0;
      end else if (load) begin
        data <= wr_data;
      end
    end
  end

endmodule

// File: rtl/telem_target_table.sv
// telem_target_table
//   Table of NUM_TARGETS target records (NUM_COORDS coordinates of COORD_W
//   bits each) with an indexed load/clear port, a global clear, a valid
//   bitmap with registered occupancy count, and a scan engine that streams
//   every valid record over a valid/ready handshake.
//
// Configuration macro: TELEM_AGE_EN (per-slot ageing driven by age_tick)
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   age_tick         age advance strobe (TELEM_AGE_EN only)
//   wr_en, wr_clr    load / clear slot wr_addr (clear wins)
//   wr_addr, wr_data slot index and record; out-of-range index is ignored
//   clr_all          clear every slot (beats wr_clr and wr_en)
//   scan_start       begin a readout scan (ignored unless idle)
//   out_valid/ready  record handshake; out_addr/out_data held while stalled
//   scan_busy        scan in progress
//   scan_done        one-cycle pulse at end of scan
//   valid_map, count per-slot valid bits and their population count
module telem_target_table
  import telem_pkg::*;
#(
  parameter int NUM_TARGETS = 32,
  parameter int COORD_W     = 8,
  parameter int NUM_COORDS  = 4,
  parameter int AGE_LIMIT   = 200,
  localparam int AW = addr_width(NUM_TARGETS),
  localparam int DW = NUM_COORDS * COORD_W,
  localparam int CW = $clog2(NUM_TARGETS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef TELEM_AGE_EN
  input  logic                   age_tick,
`endif
  input  logic                   wr_en,
  input  logic                   wr_clr,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic                   clr_all,
  input  logic                   scan_start,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AW-1:0]          out_addr,
  output logic [DW-1:0]          out_data,
  output logic                   scan_busy,
  output logic                   scan_done,
  output logic [NUM_TARGETS-1:0] valid_map,
  output logic [CW-1:0]          count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TARGETS - 1);

  if (NUM_TARGETS < 1 || AGE_LIMIT < 1) begin : g_bad_params
    $error("telem_target_table: NUM_TARGETS and AGE_LIMIT must be positive");
  end

  logic [DW-1:0]          rec [NUM_TARGETS];
  logic [NUM_TARGETS-1:0] valid_nxt;
  logic                   addr_ok;
  scan_state_t            state, state_nxt;
  logic [AW-1:0]          idx;
  logic                   idx_last;

  // Non-power-of-two tables can see addresses past the last slot.
  assign addr_ok  = ({1'b0, wr_addr} < (AW + 1)'(NUM_TARGETS));
  assign idx_last = (idx == LAST_IDX);

  // A single wr_addr serves both wr_en and wr_clr, so any wr_clr suppresses
  // the load; clr_all overrides everything.
  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_slot
    logic sel, slot_clear, slot_load;
    assign sel        = addr_ok && (wr_addr == AW'(g));
    assign slot_clear = clr_all || (wr_clr && sel);
    assign slot_load  = wr_en && !wr_clr && !clr_all && sel;

    telem_slot #(
      .DATA_W    (DW)
`ifdef TELEM_AGE_EN
      , .AGE_LIMIT (AGE_LIMIT)
`endif
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
`ifdef TELEM_AGE_EN
      .age_tick  (age_tick),
`endif
      .load      (slot_load),
      .clear     (slot_clear),
      .wr_data   (wr_data),
      .data      (rec[g]),
      .valid     (valid_map[g]),
      .valid_nxt (valid_nxt[g])
    );
  end

  function automatic logic [CW-1:0] popcount(input logic [NUM_TARGETS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Counting the slots' next-state valid bits keeps count registered yet in
  // step with valid_map on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= popcount(valid_nxt);
    end
  end

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Scan next-state: one slot tested per SEEK cycle, one beat per PRESENT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      SCAN_IDLE: begin
        if (scan_start) state_nxt = SCAN_SEEK;
      end
      SCAN_SEEK: begin
        if (valid_map[idx])  state_nxt = SCAN_PRESENT;
        else if (idx_last)   state_nxt = SCAN_DONE;
      end
      SCAN_PRESENT: begin
        if (out_ready) state_nxt = idx_last ? SCAN_DONE : SCAN_SEEK;
      end
      SCAN_DONE: begin
        state_nxt = SCAN_IDLE;
      end
      default: state_nxt = SCAN_IDLE;
    endcase
  end

  // Scan outputs are pure functions of the state.
  always_comb begin
    out_valid = (state == SCAN_PRESENT);
    scan_busy = (state != SCAN_IDLE);
    scan_done = (state == SCAN_DONE);
  end

  // Scan datapath: the presented record is captured when SEEK finds it, so
  // later writes to that slot (or clr_all) cannot disturb a stalled beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        SCAN_IDLE: begin
          if (scan_start) idx <= '0;
        end
        SCAN_SEEK: begin
          if (valid_map[idx]) begin
            out_addr <= idx;
            out_data <= rec[idx];
          end else if (!idx_last) begin
            idx <= idx + 1'b1;
          end
        end
        SCAN_PRESENT: begin
          if (out_ready && !idx_last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
